// File: rtl/axi_read_master_arbiter.sv
// Two-master round-robin AXI read arbiter; serialises whole read bursts, one outstanding at a time.
// Optional per-master completed-burst counters when AXI_RARB_PERF_EN is defined.
module axi_read_master_arbiter #(
  parameter int unsigned IDW   = 4,
  parameter int unsigned ADDRW = 32,
  parameter int unsigned LENW  = 4,
  parameter int unsigned DATAW = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [IDW-1:0]   ARID_M0,
  input  logic [ADDRW-1:0] ARADDR_M0,
  input  logic [LENW-1:0]  ARLEN_M0,
  input  logic [2:0]       ARSIZE_M0,
  input  logic [1:0]       ARBURST_M0,
  input  logic             ARVALID_M0,
  output logic             ARREADY_M0,
  input  logic [IDW-1:0]   ARID_M1,
  input  logic [ADDRW-1:0] ARADDR_M1,
  input  logic [LENW-1:0]  ARLEN_M1,
  input  logic [2:0]       ARSIZE_M1,
  input  logic [1:0]       ARBURST_M1,
  input  logic             ARVALID_M1,
  output logic             ARREADY_M1,
  output logic [IDW+3:0]   ARID_S,
  output logic [ADDRW-1:0] ARADDR_S,
  output logic [LENW-1:0]  ARLEN_S,
  output logic [2:0]       ARSIZE_S,
  output logic [1:0]       ARBURST_S,
  output logic             ARVALID_S,
  input  logic             ARREADY_S,
  input  logic [IDW+3:0]   RID_S,
  input  logic [DATAW-1:0] RDATA_S,
  input  logic [1:0]       RRESP_S,
  input  logic             RLAST_S,
  input  logic             RVALID_S,
  output logic             RREADY_S,
  output logic [IDW-1:0]   RID_M0,
  output logic [DATAW-1:0] RDATA_M0,
  output logic [1:0]       RRESP_M0,
  output logic             RLAST_M0,
  output logic             RVALID_M0,
  input  logic             RREADY_M0,
  output logic [IDW-1:0]   RID_M1,
  output logic [DATAW-1:0] RDATA_M1,
  output logic [1:0]       RRESP_M1,
  output logic             RLAST_M1,
  output logic             RVALID_M1,
  input  logic             RREADY_M1,
  output logic [1:0]       grant
`ifdef AXI_RARB_PERF_EN
  ,
  output logic [15:0]      perf_cnt_M0,
  output logic [15:0]      perf_cnt_M1
`endif
);

  localparam int unsigned MIDXW = 4;
  localparam int unsigned SIDW  = IDW + MIDXW;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_q, rr_d;       // 0: M0 has priority, 1: M1 has priority
  logic       sel_m1;
  logic       burst_done;
  logic [MIDXW-1:0] unused_rid_hi;

  assign sel_m1        = grant_q[1];
  assign grant         = grant_q;
  assign unused_rid_hi = RID_S[SIDW-1:IDW];
  assign burst_done    = (state_q == DATA) && RVALID_S && RREADY_S && RLAST_S;

  // AR payload follows the current owner; R payload is broadcast
  assign ARID_S    = sel_m1 ? {MIDXW'(1), ARID_M1} : {MIDXW'(0), ARID_M0};
  assign ARADDR_S  = sel_m1 ? ARADDR_M1  : ARADDR_M0;
  assign ARLEN_S   = sel_m1 ? ARLEN_M1   : ARLEN_M0;
  assign ARSIZE_S  = sel_m1 ? ARSIZE_M1  : ARSIZE_M0;
  assign ARBURST_S = sel_m1 ? ARBURST_M1 : ARBURST_M0;

  assign RID_M0   = RID_S[IDW-1:0];
  assign RDATA_M0 = RDATA_S;
  assign RRESP_M0 = RRESP_S;
  assign RLAST_M0 = RLAST_S;
  assign RID_M1   = RID_S[IDW-1:0];
  assign RDATA_M1 = RDATA_S;
  assign RRESP_M1 = RRESP_S;
  assign RLAST_M1 = RLAST_S;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    ARVALID_S  = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RVALID_M0  = 1'b0;
    RVALID_M1  = 1'b0;
    RREADY_S   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          // rr master wins if requesting, otherwise whichever master is requesting
          if (rr_q ? ARVALID_M1 : !ARVALID_M0) grant_d = 2'b10;
          else                                 grant_d = 2'b01;
          state_d = ADDR;
        end
      end
      ADDR: begin
        ARVALID_S  = sel_m1 ? ARVALID_M1 : ARVALID_M0;
        ARREADY_M0 = grant_q[0] && ARREADY_S;
        ARREADY_M1 = grant_q[1] && ARREADY_S;
        if (ARVALID_S && ARREADY_S) state_d = DATA;
      end
      DATA: begin
        RVALID_M0 = grant_q[0] && RVALID_S;
        RVALID_M1 = grant_q[1] && RVALID_S;
        RREADY_S  = sel_m1 ? RREADY_M1 : RREADY_M0;
        if (burst_done) begin
          rr_d    = !sel_m1;
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

`ifdef AXI_RARB_PERF_EN
  // Saturating completed-burst counters
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      perf_cnt_M0 <= 16'h0000;
      perf_cnt_M1 <= 16'h0000;
    end else if (burst_done) begin
      if (!sel_m1 && perf_cnt_M0 != 16'hFFFF) perf_cnt_M0 <= perf_cnt_M0 + 16'd1;
      if (sel_m1 && perf_cnt_M1 != 16'hFFFF)  perf_cnt_M1 <= perf_cnt_M1 + 16'd1;
    end
  end
`endif

endmodule
